mem_arbiter: RTL and testbench
==============================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter TIMEOUT_CYC, default 255: RAM-response cycles allowed per grant before abort.
REQ-002 Parameter FAIR_LIMIT, default 2: consecutive data grants tolerated while an instruction request waits (ARB_FAIR_EN only).
REQ-003 CLK  in  1  sole clock; all state updates on posedge.
REQ-004 RST  in  1  reset, asynchronous, active-high.
REQ-005 iREN  in  1  instruction read request; held until iwait low.
REQ-006 iaddr  in  32  instruction word address.
REQ-007 iwait  out  1  instruction stall; low for exactly the completion cycle.
REQ-008 iload  out  32  instruction read data, valid when iREN & !iwait.
REQ-009 dREN / dWEN  in  1 each  data read / write request, mutually exclusive, held until dwait low.
REQ-010 daddr / dstore  in  32 each  data address / write data.
REQ-011 dwait  out  1  data stall; low for exactly the completion cycle.
REQ-012 dload  out  32  data read data, valid when dREN & !dwait.
REQ-013 ramREN / ramWEN  out  1 each  RAM read / write strobe.
REQ-014 ramaddr / ramstore  out  32 each  RAM address / write data.
REQ-015 ramload  in  32  RAM read data; ram_rdy  in  1  RAM access complete this cycle.
REQ-016 timeout_err  out  1  sticky RAM-timeout flag.

Function
REQ-017 FSM states SHALL be IDLE, GRANT_D, GRANT_I; state and counters registered, RAM and wait outputs combinational from state and granted requester.
REQ-018 IDLE SHALL select GRANT_D if dREN|dWEN, else GRANT_I if iREN, else stay IDLE; data has strict priority.
REQ-019 In GRANT_D ramREN=dREN, ramWEN=dWEN, ramaddr=daddr, ramstore=dstore; in GRANT_I ramREN=1, ramWEN=0, ramaddr=iaddr, ramstore=0; in IDLE all RAM outputs 0.
REQ-020 iwait SHALL equal iREN & !(GRANT_I & ram_rdy); dwait SHALL equal (dREN|dWEN) & !(GRANT_D & ram_rdy).
REQ-021 iload and dload SHALL pass ramload during their grant, 0 otherwise.
REQ-022 ram_rdy in a GRANT state SHALL return FSM to IDLE next cycle; minimum request-to-completion latency 2 cycles (IDLE, grant with ram_rdy).
REQ-023 ram_rdy in IDLE SHALL be ignored.
REQ-024 If the granted requester drops its enables before ram_rdy, FSM SHALL return to IDLE next cycle with no completion pulse.
REQ-025 A 8-bit wait counter SHALL clear on grant entry and increment each grant cycle without ram_rdy; at TIMEOUT_CYC the grant SHALL complete with wait low one cycle, load = 32'hBAD1BAD1, timeout_err set, FSM to IDLE.
REQ-026 timeout_err SHALL remain 1 until reset; arbitration continues normally after it.
REQ-027 Simultaneous iREN and dREN arriving in IDLE SHALL grant data; instruction granted on the following IDLE cycle if still requested.

Reset
REQ-028 RST high SHALL force IDLE, counters 0, timeout_err 0, all RAM strobes 0 within the same cycle; a grant in progress is abandoned without completion.
REQ-029 After RST release the first grant SHALL occur no earlier than the first posedge.

Configuration
REQ-030 Macro ARB_FAIR_EN defined: a counter SHALL count data completions occurring while iREN is high, clear on instruction grant; when it equals FAIR_LIMIT, IDLE SHALL grant instruction over data.
REQ-031 ARB_FAIR_EN undefined: counter absent, strict data priority per REQ-018 at all times.

Verification
REQ-032 dREN=1 daddr=0x40, ram_rdy high on second grant cycle, ramload=0x1234 -> dwait low exactly one cycle, dload=0x1234, ramREN high 2 cycles.
REQ-033 iREN and dWEN asserted same cycle, ram_rdy=1 always -> GRANT_D then IDLE then GRANT_I; iwait low in cycle 4.
REQ-034 TIMEOUT_CYC=4, iREN=1, ram_rdy=0 -> iwait low after 4 grant cycles, iload=0xBAD1BAD1, timeout_err stays 1.
REQ-035 ARB_FAIR_EN, FAIR_LIMIT=2, iREN and dREN held continuously -> grant order D,D,I,D,D,I; without macro D only.
REQ-036 RST pulsed mid GRANT_D -> ramREN/ramWEN 0 immediately, no dwait drop, IDLE after release.

Source files
------------

// File: rtl/mem_arbiter.sv
// Two-requester (instruction/data) arbiter for a single RAM port with a per-grant response timeout.
// Define ARB_FAIR_EN to let a waiting instruction fetch win after FAIR_LIMIT data completions.
module mem_arbiter #(
  parameter int unsigned TIMEOUT_CYC = 255,
  parameter int unsigned FAIR_LIMIT  = 2
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        iREN,
  input  logic [31:0] iaddr,
  output logic        iwait,
  output logic [31:0] iload,
  input  logic        dREN,
  input  logic        dWEN,
  input  logic [31:0] daddr,
  input  logic [31:0] dstore,
  output logic        dwait,
  output logic [31:0] dload,
  output logic        ramREN,
  output logic        ramWEN,
  output logic [31:0] ramaddr,
  output logic [31:0] ramstore,
  input  logic [31:0] ramload,
  input  logic        ram_rdy,
  output logic        timeout_err
);

  typedef enum logic [1:0] {StIdle, StGrantD, StGrantI} state_e;

  localparam logic [7:0]  TimeoutCyc = 8'(TIMEOUT_CYC);
  localparam logic [7:0]  FairLim    = 8'(FAIR_LIMIT);
  localparam logic [31:0] AbortWord  = 32'hBAD1BAD1;

  state_e      state_q, state_d;
  logic [7:0]  wait_cnt_q, wait_cnt_d;
  logic        timeout_err_q, timeout_err_d;
  logic        d_req, grant_req, timeout, done, fair_pick;
  logic [31:0] grant_load;

  assign d_req = dREN | dWEN;

  always_comb begin
    unique case (state_q)
      StGrantD: grant_req = d_req;
      StGrantI: grant_req = iREN;
      default:  grant_req = 1'b0;
    endcase
  end

  // A real response in the same cycle as the limit wins over the abort.
  assign timeout    = grant_req & ~ram_rdy & (wait_cnt_q == TimeoutCyc);
  assign done       = grant_req & (ram_rdy | timeout);
  assign grant_load = timeout ? AbortWord : ramload;

  always_comb begin
    state_d       = state_q;
    wait_cnt_d    = wait_cnt_q;
    timeout_err_d = timeout_err_q | timeout;
    unique case (state_q)
      StIdle: begin
        wait_cnt_d = '0;
        if (fair_pick)  state_d = StGrantI;
        else if (d_req) state_d = StGrantD;
        else if (iREN)  state_d = StGrantI;
      end
      default: begin
        // Requester withdrew or access finished: either way back to arbitration.
        if (!grant_req || done) begin
          state_d    = StIdle;
          wait_cnt_d = '0;
        end else begin
          wait_cnt_d = wait_cnt_q + 8'd1;
        end
      end
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q       <= StIdle;
      wait_cnt_q    <= '0;
      timeout_err_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      wait_cnt_q    <= wait_cnt_d;
      timeout_err_q <= timeout_err_d;
    end
  end

`ifdef ARB_FAIR_EN
  logic [7:0] fair_cnt_q, fair_cnt_d;

  assign fair_pick = iREN & (fair_cnt_q >= FairLim);

  always_comb begin
    fair_cnt_d = fair_cnt_q;
    if (state_q == StIdle && state_d == StGrantI) begin
      fair_cnt_d = '0;
    end else if (state_q == StGrantD && done && iREN && fair_cnt_q < FairLim) begin
      fair_cnt_d = fair_cnt_q + 8'd1;
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) fair_cnt_q <= '0;
    else     fair_cnt_q <= fair_cnt_d;
  end
`else
  logic unused_fair_lim;
  assign unused_fair_lim = ^FairLim;
  assign fair_pick       = 1'b0;
`endif

  always_comb begin
    ramREN   = 1'b0;
    ramWEN   = 1'b0;
    ramaddr  = '0;
    ramstore = '0;
    iload    = '0;
    dload    = '0;
    iwait    = iREN  & ~((state_q == StGrantI) & done);
    dwait    = d_req & ~((state_q == StGrantD) & done);
    unique case (state_q)
      StGrantD: begin
        ramREN   = dREN;
        ramWEN   = dWEN;
        ramaddr  = daddr;
        ramstore = dstore;
        dload    = grant_load;
      end
      StGrantI: begin
        ramREN  = 1'b1;
        ramaddr = iaddr;
        iload   = grant_load;
      end
      default: ;
    endcase
  end

  assign timeout_err = timeout_err_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: cycle vector table plus hand sequences for
// timeout, mid-grant reset and back-to-back arbitration order.
module tb_mem_arbiter;

  localparam logic [31:0] IAddr  = 32'h0000_0100;
  localparam logic [31:0] DAddr  = 32'h0000_0040;
  localparam logic [31:0] DStore = 32'h0000_55AA;

  logic        CLK = 1'b0;
  logic        RST;
  logic        iREN, dREN, dWEN, ram_rdy;
  logic [31:0] iaddr, daddr, dstore, ramload;
  logic        iwait, dwait, ramREN, ramWEN, timeout_err;
  logic [31:0] iload, dload, ramaddr, ramstore;

  mem_arbiter #(
    .TIMEOUT_CYC(4),
    .FAIR_LIMIT (2)
  ) dut (
    .CLK        (CLK),
    .RST        (RST),
    .iREN       (iREN),
    .iaddr      (iaddr),
    .iwait      (iwait),
    .iload      (iload),
    .dREN       (dREN),
    .dWEN       (dWEN),
    .daddr      (daddr),
    .dstore     (dstore),
    .dwait      (dwait),
    .dload      (dload),
    .ramREN     (ramREN),
    .ramWEN     (ramWEN),
    .ramaddr    (ramaddr),
    .ramstore   (ramstore),
    .ramload    (ramload),
    .ram_rdy    (ram_rdy),
    .timeout_err(timeout_err)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic        ir, dr, dw, rdy;
    logic [31:0] rl;
    logic        push_i, push_d;
    logic        e_iw, e_dw, e_rr, e_rw;
    logic [31:0] e_ra, e_rs, e_il, e_dl;
  } vec_t;

  localparam int NV = 14;
  vec_t        vecs[NV];
  logic [31:0] exp_iq[$];
  logic [31:0] exp_dq[$];
  int          n_checks = 0;
  int          n_err    = 0;

  function automatic vec_t mk(input logic [3:0] in, input logic [31:0] rl, input logic [1:0] push,
                              input logic [3:0] e, input logic [31:0] ra, input logic [31:0] rs,
                              input logic [31:0] il, input logic [31:0] dl);
    vec_t v;
    {v.ir, v.dr, v.dw, v.rdy}     = in;
    v.rl                          = rl;
    {v.push_i, v.push_d}          = push;
    {v.e_iw, v.e_dw, v.e_rr, v.e_rw} = e;
    v.e_ra = ra;
    v.e_rs = rs;
    v.e_il = il;
    v.e_dl = dl;
    return v;
  endfunction

  task automatic chk(input string name, input logic [132:0] act, input logic [132:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Completion monitor: every read completion must match the oldest queued expectation.
  task automatic monitor();
    logic [31:0] e;
    if (!RST) begin
      if (iREN && !iwait) begin
        if (exp_iq.size() == 0) begin
          n_checks++;
          n_err++;
          $display("FAIL sb_iload: unexpected completion got %h expected none", iload);
        end else begin
          e = exp_iq.pop_front();
          chk("sb_iload", 133'(iload), 133'(e));
        end
      end
      if (dREN && !dwait) begin
        if (exp_dq.size() == 0) begin
          n_checks++;
          n_err++;
          $display("FAIL sb_dload: unexpected completion got %h expected none", dload);
        end else begin
          e = exp_dq.pop_front();
          chk("sb_dload", 133'(dload), 133'(e));
        end
      end
    end
  endtask

  task automatic sample();
    @(negedge CLK);
    monitor();
  endtask

  task automatic advance();
    @(posedge CLK);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish before 200000");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic       got;
    int         wcyc;
    logic [5:0] order, exp_order;
    logic [2:0] ng;

    // Inputs {iREN,dREN,dWEN,rdy}, ramload, push {i,d}, exp {iwait,dwait,ramREN,ramWEN}, ...
    vecs[0]  = mk(4'b0000, 32'h0,    2'b00, 4'b0000, 32'h0, 32'h0,  32'h0,   32'h0);
    vecs[1]  = mk(4'b0001, 32'hFFFF, 2'b00, 4'b0000, 32'h0, 32'h0,  32'h0,   32'h0);
    vecs[2]  = mk(4'b0100, 32'h0,    2'b00, 4'b0100, 32'h0, 32'h0,  32'h0,   32'h0);
    vecs[3]  = mk(4'b0100, 32'hAAAA, 2'b00, 4'b0110, DAddr, DStore, 32'h0,   32'hAAAA);
    vecs[4]  = mk(4'b0101, 32'h1234, 2'b01, 4'b0010, DAddr, DStore, 32'h0,   32'h1234);
    vecs[5]  = mk(4'b0000, 32'h0,    2'b00, 4'b0000, 32'h0, 32'h0,  32'h0,   32'h0);
    vecs[6]  = mk(4'b1011, 32'h777,  2'b00, 4'b1100, 32'h0, 32'h0,  32'h0,   32'h0);
    vecs[7]  = mk(4'b1011, 32'h777,  2'b00, 4'b1001, DAddr, DStore, 32'h0,   32'h777);
    vecs[8]  = mk(4'b1001, 32'h777,  2'b00, 4'b1000, 32'h0, 32'h0,  32'h0,   32'h0);
    vecs[9]  = mk(4'b1001, 32'h777,  2'b10, 4'b0010, IAddr, 32'h0,  32'h777, 32'h0);
    vecs[10] = mk(4'b0100, 32'h0,    2'b00, 4'b0100, 32'h0, 32'h0,  32'h0,   32'h0);
    vecs[11] = mk(4'b0100, 32'h0,    2'b00, 4'b0110, DAddr, DStore, 32'h0,   32'h0);
    vecs[12] = mk(4'b0000, 32'h0,    2'b00, 4'b0000, DAddr, DStore, 32'h0,   32'h0);
    vecs[13] = mk(4'b0001, 32'h5,    2'b00, 4'b0000, 32'h0, 32'h0,  32'h0,   32'h0);

    RST = 1'b1;
    {iREN, dREN, dWEN, ram_rdy} = 4'b0000;
    iaddr   = IAddr;
    daddr   = DAddr;
    dstore  = DStore;
    ramload = 32'h0;
    repeat (2) @(posedge CLK);
    #1;
    sample();
    chk("rst_ramren", 133'(ramREN), 133'(1'b0));
    chk("rst_ramwen", 133'(ramWEN), 133'(1'b0));
    chk("rst_ramaddr", 133'(ramaddr), 133'(32'h0));
    chk("rst_err", 133'(timeout_err), 133'(1'b0));
    RST = 1'b0;
    advance();

    for (int r = 0; r < NV; r++) begin
      {iREN, dREN, dWEN, ram_rdy} = {vecs[r].ir, vecs[r].dr, vecs[r].dw, vecs[r].rdy};
      ramload = vecs[r].rl;
      if (vecs[r].push_i) exp_iq.push_back(vecs[r].rl);
      if (vecs[r].push_d) exp_dq.push_back(vecs[r].rl);
      sample();
      chk($sformatf("row%0d", r),
          {iwait, dwait, ramREN, ramWEN, ramaddr, ramstore, iload, dload, timeout_err},
          {vecs[r].e_iw, vecs[r].e_dw, vecs[r].e_rr, vecs[r].e_rw, vecs[r].e_ra, vecs[r].e_rs,
           vecs[r].e_il, vecs[r].e_dl, 1'b0});
      advance();
    end

    // Instruction fetch with a silent RAM: aborts after 4 waiting grant cycles.
    iREN = 1'b1;
    ram_rdy = 1'b0;
    ramload = 32'h1111;
    exp_iq.push_back(32'hBAD1BAD1);
    got  = 1'b0;
    wcyc = 0;
    for (int c = 0; c < 20 && !got; c++) begin
      sample();
      if (ramREN && iwait) wcyc++;
      if (!iwait) got = 1'b1;
      else advance();
    end
    chk("to_completed", 133'(got), 133'(1'b1));
    chk("to_wait_cycles", 133'(wcyc), 133'(4));
    advance();
    iREN = 1'b0;
    sample();
    chk("to_err_set", 133'(timeout_err), 133'(1'b1));
    chk("to_idle", 133'(ramREN), 133'(1'b0));
    advance();

    // Normal traffic after an abort; the flag stays set.
    dREN = 1'b1;
    ram_rdy = 1'b1;
    ramload = 32'h4242;
    exp_dq.push_back(32'h4242);
    sample();
    advance();
    sample();
    chk("err_sticky", 133'(timeout_err), 133'(1'b1));
    advance();
    dREN = 1'b0;
    ram_rdy = 1'b0;

    // Reset asserted in the middle of a data grant.
    dREN = 1'b1;
    sample();
    advance();
    sample();
    chk("mid_grant_ramren", 133'(ramREN), 133'(1'b1));
    #1 RST = 1'b1;
    #1;
    chk("rst_async_ramren", 133'(ramREN), 133'(1'b0));
    chk("rst_async_ramwen", 133'(ramWEN), 133'(1'b0));
    chk("rst_async_dwait", 133'(dwait), 133'(1'b1));
    chk("rst_async_err", 133'(timeout_err), 133'(1'b0));
    advance();
    sample();
    RST = 1'b0;
    #1;
    chk("rel_no_early_grant", 133'(ramREN), 133'(1'b0));
    advance();
    ram_rdy = 1'b1;
    ramload = 32'h9999;
    exp_dq.push_back(32'h9999);
    sample();
    chk("rel_grant_ramren", 133'(ramREN), 133'(1'b1));
    advance();
    dREN = 1'b0;
    ram_rdy = 1'b0;

    // Both requesters held with an always-ready RAM: observe six grants.
`ifdef ARB_FAIR_EN
    exp_order = 6'b100100;
`else
    exp_order = 6'b000000;
`endif
    iREN = 1'b1;
    dREN = 1'b1;
    ram_rdy = 1'b1;
    ramload = 32'hC0DE_0000;
    for (int k = 0; k < 6; k++) begin
      if (exp_order[k]) exp_iq.push_back(32'hC0DE_0000);
      else exp_dq.push_back(32'hC0DE_0000);
    end
    order = '0;
    ng    = '0;
    for (int c = 0; c < 12; c++) begin
      sample();
      if (ramREN) begin
        if (ng < 3'd6) begin
          order[ng] = (ramaddr == IAddr);
          ng = ng + 3'd1;
        end
      end
      advance();
    end
    iREN = 1'b0;
    dREN = 1'b0;
    ram_rdy = 1'b0;
    sample();
    chk("order_grants", 133'(ng), 133'(3'd6));
    chk("order_pattern", 133'(order), 133'(exp_order));
    advance();

    chk("sb_i_drained", 133'(exp_iq.size()), 133'(0));
    chk("sb_d_drained", 133'(exp_dq.size()), 133'(0));

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
